// File: rtl/phys_reg_free_list_ctrl.sv
// Free list of physical register IDs for rename: circular FIFO with an init fill,
// commit-side reclaim and a single branch checkpoint of the allocation pointer.
module phys_reg_free_list_ctrl #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int PREG_W   = $clog2(NUM_PHYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              release_valid,
  input  logic [PREG_W-1:0] release_preg,
  input  logic              ckpt_take,
  input  logic              ckpt_restore,
  output logic              init_done,
  output logic [PREG_W:0]   free_count,
  output logic              overflow_err
);
  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = PREG_W + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [PREG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail, ckpt_head;
  logic [PTR_W-1:0]  head_next, tail_next, span;
  logic [CNT_W-1:0]  count, count_next;
  logic [IDX_W-1:0]  init_ctr;
  logic              run, pop, push, drop, restore_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    init_done   = 1'b0;
    alloc_ready = 1'b0;
    alloc_preg  = '0;
    case (state)
      INIT: if (init_ctr == IDX_W'(DEPTH - 1)) state_next = RUN;
      RUN: begin
        init_done   = 1'b1;
        alloc_ready = (count != '0) && !ckpt_restore;
        alloc_preg  = mem[head[IDX_W-1:0]];
      end
      default: state_next = INIT;
    endcase
  end

  // A release into a full pool is still legal when a pop frees the slot in the same cycle.
  always_comb begin
    run         = (state == RUN);
    pop         = alloc_req && alloc_ready;
    push        = run && release_valid && ((count < CNT_W'(DEPTH)) || pop);
    drop        = run && release_valid && !push;
    head_next   = ckpt_restore ? ckpt_head : head + PTR_W'(pop);
    tail_next   = tail + PTR_W'(push);
    span        = tail_next - ckpt_head;
    restore_ovf = CNT_W'(span) > CNT_W'(DEPTH);
    if (ckpt_restore)
      count_next = restore_ovf ? CNT_W'(DEPTH) : CNT_W'(span);
    else
      count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_ctr     <= '0;
      head         <= '0;
      tail         <= '0;
      ckpt_head    <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (!run) begin
      init_ctr <= init_ctr + 1'b1;
      tail     <= tail + 1'b1;
      count    <= count + 1'b1;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      if (ckpt_take && !ckpt_restore) ckpt_head <= head_next;
      if (drop || (ckpt_restore && restore_ovf)) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)      mem[init_ctr]          <= PREG_W'(NUM_ARCH) + PREG_W'(init_ctr);
      else if (push) mem[tail[IDX_W-1:0]]   <= release_preg;
    end
  end

  assign free_count = count;

endmodule

// File: tb/tb_phys_reg_free_list_ctrl.sv
// Bench for phys_reg_free_list_ctrl: directed table, corner sequences and random
// traffic checked against an absolute-position ring model of the free list.
module tb_phys_reg_free_list_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, alloc_req, release_valid, ckpt_take, ckpt_restore;
  logic [5:0] release_preg;
  logic       alloc_ready, init_done, overflow_err;
  logic [5:0] alloc_preg;
  logic [6:0] free_count;

  int n_tests = 0;
  int n_fail  = 0;

  phys_reg_free_list_ctrl dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_preg(alloc_preg), .release_valid(release_valid), .release_preg(release_preg),
    .ckpt_take(ckpt_take), .ckpt_restore(ckpt_restore), .init_done(init_done),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Model: positions are unbounded integers; hardware pointers are these modulo 64.
  bit m_valid = 0;
  bit m_run, m_ovf;
  int m_ictr, m_h, m_t, m_ck, m_cnt;
  int m_mem [32];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int er;
    er = (m_run && m_cnt != 0 && !ckpt_restore) ? 1 : 0;
    chk("model_ready", int'(alloc_ready), er);
    chk("model_preg", int'(alloc_preg), m_run ? m_mem[m_h % 32] : 0);
    chk("model_count", int'(free_count), m_cnt);
    chk("model_init_done", int'(init_done), int'(m_run));
    chk("model_ovf", int'(overflow_err), int'(m_ovf));
  endtask

  task automatic model_update(input bit rst, input bit req, input bit rv, input int rp,
                              input bit take, input bit rest);
    bit pop, push;
    int hn, tn, d;
    m_valid = 1;
    if (!rst) begin
      m_run = 0; m_ictr = 0; m_h = 0; m_t = 0; m_ck = 0; m_cnt = 0; m_ovf = 0;
    end else if (!m_run) begin
      m_mem[m_ictr] = 32 + m_ictr;
      m_t++; m_cnt++; m_ictr++;
      if (m_ictr == 32) m_run = 1;
    end else begin
      pop  = req && m_cnt != 0 && !rest;
      push = rv && (m_cnt < 32 || pop);
      if (rv && !push) m_ovf = 1;
      if (push) m_mem[m_t % 32] = rp;
      hn = rest ? m_ck : m_h + int'(pop);
      tn = m_t + int'(push);
      if (rest) begin
        d = (((tn - m_ck) % 64) + 64) % 64;
        if (d > 32) begin m_ovf = 1; d = 32; end
        m_cnt = d;
      end else begin
        m_cnt = m_cnt + int'(push) - int'(pop);
      end
      if (take && !rest) m_ck = hn;
      m_h = hn; m_t = tn;
    end
  endtask

  task automatic do_cycle(input bit rst, input bit req, input bit rv, input int rp,
                          input bit take, input bit rest);
    rst_n = rst; alloc_req = req; release_valid = rv; release_preg = 6'(rp);
    ckpt_take = take; ckpt_restore = rest;
    #2;
    if (m_valid) model_check();
    @(posedge clk);
    model_update(rst, req, rv, rp, take, rest);
    #1;
  endtask

  task automatic idle();
    do_cycle(1, 0, 0, 0, 0, 0);
  endtask

  // Park inputs idle and let combinational outputs settle for a constant check.
  task automatic settle_idle();
    rst_n = 1; alloc_req = 0; release_valid = 0; release_preg = 0;
    ckpt_take = 0; ckpt_restore = 0;
    #1;
  endtask

  typedef struct {
    bit req; bit rv; int rp; bit take; bit rest;
    int ready; int preg; int cnt;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 0, 1, 32, 32};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 32, 32};
    tbl[2]  = '{1, 0, 0, 0, 0, 1, 33, 31};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 34, 30};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 35, 29};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 32, 32};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 33, 31};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 34, 30};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 35, 29};
    tbl[9]  = '{1, 1, 9, 0, 0, 1, 35, 29};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 36, 29};

    // Reset and initial fill.
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    settle_idle();
    chk("reset_init_done", int'(init_done), 0);
    chk("reset_count", int'(free_count), 0);
    chk("reset_ovf", int'(overflow_err), 0);
    for (int i = 0; i < 32; i++) begin
      settle_idle();
      chk("init_wait", int'(init_done), 0);
      idle();
    end
    settle_idle();
    chk("init_done", int'(init_done), 1);
    chk("init_count", int'(free_count), 32);
    chk("init_ready", int'(alloc_ready), 1);
    chk("init_preg", int'(alloc_preg), 32);

    // Checkpoint/restore and alloc stream.
    for (int i = 0; i < 11; i++) begin
      rst_n = 1; alloc_req = tbl[i].req; release_valid = tbl[i].rv;
      release_preg = 6'(tbl[i].rp); ckpt_take = tbl[i].take; ckpt_restore = tbl[i].rest;
      #1;
      chk($sformatf("tbl%0d_ready", i), int'(alloc_ready), tbl[i].ready);
      chk($sformatf("tbl%0d_preg", i), int'(alloc_preg), tbl[i].preg);
      chk($sformatf("tbl%0d_count", i), int'(free_count), tbl[i].cnt);
      do_cycle(1, tbl[i].req, tbl[i].rv, tbl[i].rp, tbl[i].take, tbl[i].rest);
    end

    // Drain, then a single release becomes allocatable next cycle.
    for (int i = 0; i < 29; i++) do_cycle(1, 1, 0, 0, 0, 0);
    settle_idle();
    chk("drain_ready", int'(alloc_ready), 0);
    chk("drain_count", int'(free_count), 0);
    do_cycle(1, 1, 1, 5, 0, 0);
    settle_idle();
    chk("rel5_ready", int'(alloc_ready), 1);
    chk("rel5_preg", int'(alloc_preg), 5);
    chk("rel5_count", int'(free_count), 1);

    // Simultaneous pop+push at count 10: ID 7 comes back behind the older entries.
    for (int i = 0; i < 9; i++) do_cycle(1, 0, 1, 40 + i, 0, 0);
    do_cycle(1, 1, 1, 7, 0, 0);
    settle_idle();
    chk("popush_count", int'(free_count), 10);
    for (int i = 0; i < 10; i++) begin
      settle_idle();
      chk($sformatf("order%0d", i), int'(alloc_preg), (i < 9) ? 40 + i : 7);
      do_cycle(1, 1, 0, 0, 0, 0);
    end
    settle_idle();
    chk("order_empty", int'(free_count), 0);

    // Full pool: pop+push is legal, a bare release is dropped and sticky.
    do_cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) idle();
    do_cycle(1, 1, 1, 3, 0, 0);
    settle_idle();
    chk("full_popush_ovf", int'(overflow_err), 0);
    chk("full_popush_count", int'(free_count), 32);
    do_cycle(1, 0, 1, 4, 0, 0);
    idle();
    settle_idle();
    chk("drop_ovf", int'(overflow_err), 1);
    chk("drop_count", int'(free_count), 32);

    // Reset mid-INIT restarts the fill and clears the sticky error.
    do_cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle();
    do_cycle(0, 0, 0, 0, 0, 0);
    settle_idle();
    chk("midinit_ovf", int'(overflow_err), 0);
    chk("midinit_count", int'(free_count), 0);
    for (int i = 0; i < 32; i++) begin
      settle_idle();
      chk("reinit_wait", int'(init_done), 0);
      idle();
    end
    settle_idle();
    chk("reinit_done", int'(init_done), 1);
    chk("reinit_count", int'(free_count), 32);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(499, 0) != 0),
               ($urandom_range(9, 0) < 6),
               ($urandom_range(1, 0) == 1),
               int'($urandom_range(63, 0)),
               ($urandom_range(9, 0) == 0),
               ($urandom_range(19, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list_ctrl.md
Name: phys_reg_free_list_ctrl

Overview:
Sequencing controller for the pool of physical registers used by the rename stage's map table. It owns a circular FIFO of free physical register IDs and hands one ID per cycle to rename through a ready/request handshake. It reclaims IDs released by the commit/active-list stage. It holds a single branch checkpoint of the allocation pointer, so a mispredict flush returns speculatively allocated registers in one cycle.

Parameters:
NUM_PHYS, 64, total physical registers
NUM_ARCH, 32, architectural registers; physical 0..NUM_ARCH-1 are mapped at reset
PREG_W, 6, physical register ID width, equal to clog2(NUM_PHYS)
DEPTH (local), NUM_PHYS-NUM_ARCH = 32, FIFO capacity

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  reset: synchronous, active-low
alloc_req  input  1  rename consumes alloc_preg this cycle
alloc_ready  output  1  a free ID is available and allocation is permitted
alloc_preg  output  PREG_W  ID at FIFO head; valid when alloc_ready=1
release_valid  input  1  commit returns release_preg to the pool
release_preg  input  PREG_W  freed physical ID (previous mapping of the committed dest)
ckpt_take  input  1  snapshot allocation pointer (branch renamed)
ckpt_restore  input  1  mispredict: rewind allocation pointer to the snapshot
init_done  output  1  initial fill complete
free_count  output  PREG_W+1  current number of free IDs
overflow_err  output  1  sticky: release dropped or restore exceeded capacity

Behaviour:
- Storage: mem[DEPTH] of PREG_W. head/tail/ckpt_head are PREG_W bits: log2(DEPTH) index bits plus a wrap bit. count is PREG_W+1 bits.
- Reset (rst_n=0 at posedge): state=INIT, init_ctr=0, head=tail=ckpt_head=0, count=0, init_done=0, overflow_err=0. alloc_ready=0 and alloc_preg=0 while not in RUN.
- FSM INIT: each cycle writes mem[init_ctr]=NUM_ARCH+init_ctr and increments tail, count and init_ctr. After the DEPTH-th write, the next state is RUN. RUN is reached exactly DEPTH cycles after reset deasserts, with count=DEPTH.
- INIT ignores alloc_req, release_valid, ckpt_take and ckpt_restore. rst_n low in any state, including mid-INIT, restarts INIT from 0.
- FSM RUN: init_done=1. No other states exist.
- alloc_ready = (count!=0) && !ckpt_restore. alloc_preg = mem[head], combinational and zero-latency.
- Pop: alloc_req && alloc_ready, so head<=head+1. alloc_req while alloc_ready=0 is a no-op. There is no release-to-alloc bypass; an ID released in cycle N is allocatable from N+1 at the earliest.
- Push: release_valid with count<DEPTH writes mem[tail]<=release_preg and sets tail<=tail+1. If count==DEPTH and no pop occurs the same cycle, the release is dropped and overflow_err<=1.
- Simultaneous pop+push: both apply and count is unchanged. This is legal even at count==DEPTH.
- count_next = count + push - pop, except on restore (below).
- ckpt_take: ckpt_head<=head_next, which includes any pop in the same cycle.
- ckpt_restore: head<=ckpt_head, with no pop that cycle. A push in the same cycle is still accepted. count<=tail_next-ckpt_head (modulo arithmetic with the wrap bit). If that result exceeds DEPTH, overflow_err<=1 and count saturates to DEPTH.
- ckpt_take and ckpt_restore in the same cycle: restore wins and ckpt_head is unchanged.
- Before any ckpt_take, ckpt_head holds its reset value 0.
- Pointers wrap modulo DEPTH on index bits; the wrap bit toggles.
- overflow_err is cleared only by reset.

Test Plan:
- Reset for 2 cycles, release rst_n -> init_done=0 for 32 cycles, then init_done=1, free_count=32, alloc_ready=1, alloc_preg=32.
- alloc_req held 3 cycles after init -> alloc_preg 32,33,34 on successive cycles; free_count 29.
- 32 allocs drain the pool -> alloc_ready=0, free_count=0. Then release_preg=5 -> next cycle alloc_ready=1, alloc_preg=5, free_count=1.
- count=10 with alloc_req and release_valid (preg 7) in the same cycle -> free_count stays 10; preg 7 is returned after the 10 older entries.
- ckpt_take with head at 32 (no alloc), then alloc 32,33,34, then ckpt_restore -> alloc_ready=0 in the restore cycle; next cycle alloc_preg=32, free_count=32.
- Full pool, release_valid with no alloc -> overflow_err=1, free_count=32. Assert rst_n low mid-INIT (cycle 10) -> overflow_err=0 and init restarts, completing 32 cycles after release.
